// File: rtl/spike_sprite_fetch.sv
// Spike sprite address generator: double-buffered spike table, per-pixel hit test,
// ROM address drive and latency-aligned opaque/palette output (3-cycle pipeline).
module spike_sprite_fetch #(
  parameter int unsigned NUM_SPIKES      = 8,
  parameter logic [2:0]  TRANSPARENT_IDX = 3'd0,
  localparam int unsigned IW = (NUM_SPIKES > 1) ? $clog2(NUM_SPIKES) : 1
) (
  input  logic          clock_i,
  input  logic          reset_n_i,
  input  logic          frame_start_i,
  input  logic          wr_en_i,
  input  logic [IW-1:0] wr_idx_i,
  input  logic [10:0]   wr_x_i,
  input  logic [9:0]    wr_y_i,
  input  logic          wr_active_i,
  input  logic [10:0]   scroll_x_i,
  input  logic          pix_valid_i,
  input  logic [9:0]    draw_x_i,
  input  logic [9:0]    draw_y_i,
  output logic [9:0]    rom_addr_o,
  input  logic [2:0]    rom_q_i,
  output logic          out_valid_o,
  output logic          out_hit_o,
  output logic [2:0]    out_idx_o
);

  logic [10:0] pend_x_q [NUM_SPIKES];
  logic [9:0]  pend_y_q [NUM_SPIKES];
  logic        pend_a_q [NUM_SPIKES];
  logic [10:0] act_x_q  [NUM_SPIKES];
  logic [9:0]  act_y_q  [NUM_SPIKES];
  logic        act_a_q  [NUM_SPIKES];
  logic [10:0] scroll_q;

  logic [9:0]  rom_addr_q;
  logic        hit_s1_q, valid_s1_q;
  logic        hit_s2_q, valid_s2_q;
  logic        out_valid_q, out_hit_q;
  logic [2:0]  out_idx_q;

  logic        hit_d;
  logic [9:0]  addr_d;
  logic [11:0] dx, dy;
  logic        opaque;

  // A write coinciding with frame_start is forwarded straight into the active table.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < int'(NUM_SPIKES); i++) begin
        pend_x_q[i] <= '0;
        pend_y_q[i] <= '0;
        pend_a_q[i] <= 1'b0;
        act_x_q[i]  <= '0;
        act_y_q[i]  <= '0;
        act_a_q[i]  <= 1'b0;
      end
      scroll_q <= '0;
    end else begin
      if (wr_en_i) begin
        pend_x_q[wr_idx_i] <= wr_x_i;
        pend_y_q[wr_idx_i] <= wr_y_i;
        pend_a_q[wr_idx_i] <= wr_active_i;
      end
      if (frame_start_i) begin
        for (int i = 0; i < int'(NUM_SPIKES); i++) begin
          if (wr_en_i && (wr_idx_i == IW'(i))) begin
            act_x_q[i] <= wr_x_i;
            act_y_q[i] <= wr_y_i;
            act_a_q[i] <= wr_active_i;
          end else begin
            act_x_q[i] <= pend_x_q[i];
            act_y_q[i] <= pend_y_q[i];
            act_a_q[i] <= pend_a_q[i];
          end
        end
        scroll_q <= scroll_x_i;
      end
    end
  end

  // Scan from the highest index down so the lowest-index hit wins.
  always_comb begin
    hit_d  = 1'b0;
    addr_d = '0;
    dx     = '0;
    dy     = '0;
    for (int i = int'(NUM_SPIKES) - 1; i >= 0; i--) begin
      dx = {2'b00, draw_x_i} + {1'b0, scroll_q} - {1'b0, act_x_q[i]};
      dy = {2'b00, draw_y_i} - {2'b00, act_y_q[i]};
      if (act_a_q[i] && pix_valid_i && (dx[11:5] == 7'd0) && (dy[11:5] == 7'd0)) begin
        hit_d  = 1'b1;
        addr_d = {dy[4:0], dx[4:0]};
      end
    end
  end

  assign opaque = hit_s2_q && (rom_q_i != TRANSPARENT_IDX);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rom_addr_q  <= '0;
      hit_s1_q    <= 1'b0;
      valid_s1_q  <= 1'b0;
      hit_s2_q    <= 1'b0;
      valid_s2_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      rom_addr_q  <= addr_d;
      hit_s1_q    <= hit_d;
      valid_s1_q  <= pix_valid_i;
      hit_s2_q    <= hit_s1_q;
      valid_s2_q  <= valid_s1_q;
      out_valid_q <= valid_s2_q;
      out_hit_q   <= opaque;
      out_idx_q   <= opaque ? rom_q_i : 3'd0;
    end
  end

  assign rom_addr_o  = rom_addr_q;
  assign out_valid_o = out_valid_q;
  assign out_hit_o   = out_hit_q;
  assign out_idx_o   = out_idx_q;

endmodule

// File: tb/tb_spike_sprite_fetch.sv
// Bench for spike_sprite_fetch: directed scenarios plus randomized traffic, checked
// against a screen-space model of the spike table with a 1024-entry ROM behind the DUT.
module tb_spike_sprite_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0, wr_en = 1'b0, wr_active = 1'b0, pix_valid = 1'b0;
  logic [2:0]  wr_idx = '0;
  logic [10:0] wr_x = '0, scroll_x = '0;
  logic [9:0]  wr_y = '0, draw_x = '0, draw_y = '0;
  logic [9:0]  rom_addr;
  logic [2:0]  rom_q = '0;
  logic        out_valid, out_hit;
  logic [2:0]  out_idx;

  spike_sprite_fetch dut (
    .clock_i(clk), .reset_n_i(rst_n), .frame_start_i(frame_start),
    .wr_en_i(wr_en), .wr_idx_i(wr_idx), .wr_x_i(wr_x), .wr_y_i(wr_y),
    .wr_active_i(wr_active), .scroll_x_i(scroll_x), .pix_valid_i(pix_valid),
    .draw_x_i(draw_x), .draw_y_i(draw_y), .rom_addr_o(rom_addr), .rom_q_i(rom_q),
    .out_valid_o(out_valid), .out_hit_o(out_hit), .out_idx_o(out_idx)
  );

  always #5 clk = ~clk;

  logic [2:0] rom_mem [1024];
  always @(posedge clk) rom_q <= rom_mem[rom_addr];

  typedef struct { int x; int y; bit act; } ent_t;
  ent_t pend [8];
  ent_t actv [8];
  int   scroll;

  int exp_addr1;
  bit hv [3];
  bit hh [3];
  int hi [3];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      pend[i] = '{0, 0, 1'b0};
      actv[i] = '{0, 0, 1'b0};
    end
    scroll = 0;
    exp_addr1 = 0;
    for (int i = 0; i < 3; i++) begin hv[i] = 0; hh[i] = 0; hi[i] = 0; end
  endtask

  // Screen-space test: spike i occupies columns [x-scroll, x-scroll+31], rows [y, y+31].
  task automatic predict(input bit pv, input int px, input int py, output bit hit, output int addr);
    hit = 0; addr = 0;
    if (pv) begin
      for (int i = 0; i < 8; i++) begin
        int col, row;
        col = px - (actv[i].x - scroll);
        row = py - actv[i].y;
        if (!hit && actv[i].act && col >= 0 && col < 32 && row >= 0 && row < 32) begin
          hit = 1;
          addr = row * 32 + col;
        end
      end
    end
  endtask

  task automatic cycle(input bit fs, input bit we, input int widx, input int wx, input int wy,
                       input bit wa, input int sx, input bit pv, input int px, input int py);
    bit hit;
    int addr;
    @(negedge clk);
    chk("rom_addr", 32'(rom_addr), 32'(exp_addr1));
    chk("out_valid", 32'(out_valid), 32'(hv[2]));
    chk("out_hit", 32'(out_hit), 32'(hh[2]));
    chk("out_idx", 32'(out_idx), 32'(hi[2]));
    frame_start = fs; wr_en = we; wr_idx = 3'(widx); wr_x = 11'(wx); wr_y = 10'(wy);
    wr_active = wa; scroll_x = 11'(sx); pix_valid = pv; draw_x = 10'(px); draw_y = 10'(py);
    predict(pv, px, py, hit, addr);
    hv[2] = hv[1]; hh[2] = hh[1]; hi[2] = hi[1];
    hv[1] = hv[0]; hh[1] = hh[0]; hi[1] = hi[0];
    hv[0] = pv;
    hh[0] = hit && (rom_mem[addr] != 3'd0);
    hi[0] = hh[0] ? int'(rom_mem[addr]) : 0;
    exp_addr1 = addr;
    if (we) pend[widx] = '{wx, wy, wa};
    if (fs) begin
      for (int i = 0; i < 8; i++) actv[i] = pend[i];
      scroll = sx;
    end
  endtask

  task automatic idle(input int n, input int sx);
    for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 0, sx, 0, 0, 0);
  endtask

  task automatic pix(input int sx, input int px, input int py);
    cycle(0, 0, 0, 0, 0, 0, sx, 1, px, py);
  endtask

  task automatic rand_cycles(input int n);
    bit fs, we, wa, pv;
    int widx, wx, wy, sx, px, py;
    for (int k = 0; k < n; k++) begin
      fs   = ($urandom_range(0, 39) == 0);
      we   = ($urandom_range(0, 5) == 0);
      wa   = ($urandom_range(0, 3) != 0);
      widx = $urandom_range(0, 7);
      wx   = $urandom_range(0, 300);
      wy   = $urandom_range(0, 100);
      sx   = $urandom_range(0, 200);
      pv   = ($urandom_range(0, 4) != 0);
      px   = $urandom_range(0, 127);
      py   = $urandom_range(0, 127);
      cycle(fs, we, widx, wx, wy, wa, sx, pv, px, py);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    for (int a = 0; a < 1024; a++) rom_mem[a] = 3'($urandom_range(0, 7));
    rom_mem[170] = 3'd5;
    model_reset();

    idle(2, 0);
    chk("reset_rom_addr", 32'(rom_addr), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    rst_n = 1'b1;
    idle(3, 0);

    // Single hit: spike at world (200,100), scroll 150.
    cycle(0, 1, 0, 200, 100, 1, 150, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 150, 0, 0, 0);
    pix(150, 60, 105);
    idle(1, 150);
    chk("single_addr", 32'(rom_addr), 170);
    idle(2, 150);
    chk("single_valid", 32'(out_valid), 1);
    chk("single_hit", 32'(out_hit), 1);
    chk("single_idx", 32'(out_idx), 5);

    // Transparent ROM data at the same pixel, then a miss at column 10.
    idle(2, 150);
    rom_mem[170] = 3'd0;
    pix(150, 60, 105);
    pix(150, 10, 105);
    chk("miss_addr_prev_hit", 32'(rom_addr), 170);
    idle(1, 150);
    chk("miss_addr", 32'(rom_addr), 0);
    idle(1, 150);
    chk("transp_valid", 32'(out_valid), 1);
    chk("transp_hit", 32'(out_hit), 0);
    chk("transp_idx", 32'(out_idx), 0);
    idle(1, 150);
    chk("miss_hit", 32'(out_hit), 0);

    // Overlap: entries 2 and 5 both cover (40,40); entry 2 must win.
    cycle(0, 1, 2, 30, 30, 1, 0, 0, 0, 0);
    cycle(0, 1, 5, 20, 20, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pix(0, 40, 40);
    idle(1, 0);
    chk("overlap_addr", 32'(rom_addr), 330);
    idle(2, 0);

    // Left clip: spike screen x = -10.
    cycle(1, 1, 3, 90, 0, 1, 100, 0, 0, 0);
    pix(100, 0, 0);
    pix(100, 21, 0);
    chk("clip_col10", 32'(rom_addr), 10);
    pix(100, 22, 0);
    chk("clip_col31", 32'(rom_addr), 31);
    idle(1, 100);
    chk("clip_miss", 32'(rom_addr), 0);
    idle(2, 100);

    // Double buffering: mid-frame write is invisible until frame_start.
    cycle(0, 1, 1, 300, 50, 1, 100, 0, 0, 0);
    pix(100, 205, 55);
    idle(1, 100);
    chk("dbuf_pending_addr", 32'(rom_addr), 0);
    cycle(1, 0, 0, 0, 0, 0, 100, 0, 0, 0);
    pix(100, 205, 55);
    idle(1, 100);
    chk("dbuf_commit_addr", 32'(rom_addr), 5 * 32 + 5);
    cycle(1, 1, 4, 400, 60, 1, 100, 0, 0, 0);
    pix(100, 305, 65);
    idle(1, 100);
    chk("dbuf_coincident_addr", 32'(rom_addr), 5 * 32 + 5);
    pix(500, 305, 65);
    idle(1, 500);
    chk("scroll_ignored_addr", 32'(rom_addr), 5 * 32 + 5);
    idle(2, 500);

    rand_cycles(1500);

    // Asynchronous reset in the middle of traffic.
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 40, 40);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_rom_addr", 32'(rom_addr), 0);
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_hit", 32'(out_hit), 0);
    chk("async_rst_idx", 32'(out_idx), 0);
    model_reset();
    idle(2, 0);
    rst_n = 1'b1;
    idle(4, 0);

    rand_cycles(1500);
    idle(4, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
